credit_arbiter: RTL and testbench

CREDIT_ARBITER -- requirements
Module: credit_arbiter

---
 rtl/credit_arb_pkg.sv | 19 +
 rtl/credit_arbiter_rr_select.sv | 37 +++
 rtl/credit_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_credit_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/credit_arb_pkg.sv
// Shared types and default constants for the credit-based link arbiter.
package credit_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      STALL = 2'd2
   } arb_state_t;

   localparam int DEF_NREQ         = 4;
   localparam int DEF_NBITS        = 4;
   localparam int DEF_INIT_CREDITS = 8;
   localparam int DEF_TIMEOUT      = 64;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/credit_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_select
   import credit_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);

   logic found_s;

   // Two passes: indices from ptr upward, then the wrapped low indices.
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found_s && req[j] && (j >= int'(ptr))) begin
            grant[j] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found_s && req[j]) begin
            grant[j] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

endmodule

// File: rtl/credit_arbiter.sv
// Credit-gated round-robin link arbiter with packet-granular ownership.
// Optional stall watchdog enabled by defining CREDIT_ARB_TIMEOUT_EN.
module credit_arbiter
   import credit_arb_pkg::*;
#(
   parameter int NREQ         = DEF_NREQ,
   parameter int NBITS        = DEF_NBITS,
   parameter int INIT_CREDITS = DEF_INIT_CREDITS
`ifdef CREDIT_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT      = DEF_TIMEOUT
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  last,
   output logic [NREQ-1:0]  grant,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic             credit_ret,
   output logic [NBITS-1:0] credits,
   output logic             credit_ovf
`ifdef CREDIT_ARB_TIMEOUT_EN
   ,
   output logic             stall_err
`endif
);

   localparam int              PW    = ptr_width(NREQ);
   localparam logic [NBITS-1:0] CMAX  = {NBITS{1'b1}};
   localparam logic [NBITS-1:0] CINIT = NBITS'(INIT_CREDITS);

   arb_state_t       state_r, state_nxt_s;
   logic [NREQ-1:0]  grant_r, grant_nxt_s, rr_grant_s;
   logic [PW-1:0]    ptr_r, ptr_nxt_s, ptr_inc_s;
   logic [NBITS-1:0] credits_r, credits_nxt_s;
   logic             ovf_r, ovf_nxt_s;
   logic             owner_req_s, owner_last_s, tx_valid_s, send_s;

`ifdef CREDIT_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] stall_cnt_r, stall_cnt_nxt_s;
   logic          stall_err_r, stall_err_nxt_s;
   assign stall_err = stall_err_r;
`endif

   rr_select #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req   (req),
      .ptr   (ptr_r),
      .grant (rr_grant_s)
   );

   assign owner_req_s  = |(req & grant_r);
   assign owner_last_s = |(last & grant_r);
   // Gated by RST so a packet being abandoned cannot emit a beat in the reset cycle.
   assign tx_valid_s   = (state_r == BUSY) && owner_req_s && (credits_r != '0) && !RST;
   assign send_s       = tx_valid_s && tx_ready;

   assign grant      = grant_r;
   assign tx_valid   = tx_valid_s;
   assign credits    = credits_r;
   assign credit_ovf = ovf_r;

   // Pointer value that follows the current owner.
   always_comb begin
      ptr_inc_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_r[i]) begin
            ptr_inc_s = PW'((i + 1) % NREQ);
         end else begin
            ptr_inc_s = ptr_inc_s;
         end
      end
   end

   // Credit counter update with saturation on return.
   always_comb begin
      credits_nxt_s = credits_r;
      ovf_nxt_s     = 1'b0;
      if (credit_ret && !send_s) begin
         if (credits_r == CMAX) begin
            ovf_nxt_s     = 1'b1;
         end else begin
            credits_nxt_s = credits_r + NBITS'(1);
         end
      end else if (send_s && !credit_ret) begin
         credits_nxt_s = credits_r - NBITS'(1);
      end else begin
         credits_nxt_s = credits_r;
      end
   end

   // Next-state, grant and pointer decode.
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      ptr_nxt_s   = ptr_r;
`ifdef CREDIT_ARB_TIMEOUT_EN
      stall_cnt_nxt_s = '0;
      stall_err_nxt_s = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            // A freshly registered grant spends one cycle here before beats flow.
            if (grant_r != '0) begin
               if (owner_req_s) begin
                  state_nxt_s = BUSY;
               end else begin
                  grant_nxt_s = '0;
                  ptr_nxt_s   = ptr_inc_s;
               end
            end else if ((req != '0) && (credits_r != '0)) begin
               grant_nxt_s = rr_grant_s;
            end else begin
               grant_nxt_s = '0;
            end
         end
         BUSY: begin
            if ((send_s && owner_last_s) || !owner_req_s) begin
               state_nxt_s = IDLE;
               grant_nxt_s = '0;
               ptr_nxt_s   = ptr_inc_s;
            end else if (credits_nxt_s == '0) begin
               state_nxt_s = STALL;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         STALL: begin
            if (!owner_req_s) begin
               state_nxt_s = IDLE;
               grant_nxt_s = '0;
               ptr_nxt_s   = ptr_inc_s;
            end else if (credit_ret) begin
               state_nxt_s = BUSY;
            end
`ifdef CREDIT_ARB_TIMEOUT_EN
            else if (stall_cnt_r == TW'(TIMEOUT - 1)) begin
               state_nxt_s     = IDLE;
               grant_nxt_s     = '0;
               ptr_nxt_s       = ptr_inc_s;
               stall_err_nxt_s = 1'b1;
            end else begin
               stall_cnt_nxt_s = stall_cnt_r + TW'(1);
            end
`else
            else begin
               state_nxt_s = STALL;
            end
`endif
         end
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = '0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= IDLE;
         grant_r   <= '0;
         ptr_r     <= '0;
         credits_r <= CINIT;
         ovf_r     <= 1'b0;
`ifdef CREDIT_ARB_TIMEOUT_EN
         stall_cnt_r <= '0;
         stall_err_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         grant_r   <= grant_nxt_s;
         ptr_r     <= ptr_nxt_s;
         credits_r <= credits_nxt_s;
         ovf_r     <= ovf_nxt_s;
`ifdef CREDIT_ARB_TIMEOUT_EN
         stall_cnt_r <= stall_cnt_nxt_s;
         stall_err_r <= stall_err_nxt_s;
`endif
      end
   end

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed self-checking bench for credit_arbiter (NREQ=4, NBITS=4, INIT_CREDITS=8).
module tb_credit_arbiter;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] req, last, grant, credits;
   logic       tx_valid, tx_ready, credit_ret, credit_ovf;
`ifdef CREDIT_ARB_TIMEOUT_EN
   logic       stall_err;
`endif
   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   credit_arbiter #(
      .NREQ(4), .NBITS(4), .INIT_CREDITS(8)
`ifdef CREDIT_ARB_TIMEOUT_EN
      , .TIMEOUT(4)
`endif
   ) dut (
      .CLK(CLK), .RST(RST), .req(req), .last(last), .grant(grant),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .credit_ret(credit_ret),
      .credits(credits), .credit_ovf(credit_ovf)
`ifdef CREDIT_ARB_TIMEOUT_EN
      , .stall_err(stall_err)
`endif
   );

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic test_reset();
      RST = 1'b1; req = 4'b0000; last = 4'b0000; tx_ready = 1'b0; credit_ret = 1'b0;
      cyc(); cyc();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b want 0000", grant); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
      checks++; if (credits !== 4'd8) begin errors++; $display("FAIL rst_credits got %0d want 8", credits); end
      checks++; if (credit_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", credit_ovf); end
`ifdef CREDIT_ARB_TIMEOUT_EN
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL rst_stall_err got %b want 0", stall_err); end
`endif
      RST = 1'b0;
   endtask

   task automatic test_single_packet();
      req = 4'b0001; tx_ready = 1'b1;
      cyc();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sp_grant got %b want 0001", grant); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL sp_latency got %b want 0", tx_valid); end
      cyc();
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL sp_first_valid got %b want 1", tx_valid); end
      cyc();
      checks++; if (credits !== 4'd7) begin errors++; $display("FAIL sp_credits1 got %0d want 7", credits); end
      cyc();
      last = 4'b0001;
      cyc();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL sp_end_grant got %b want 0000", grant); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL sp_end_valid got %b want 0", tx_valid); end
      checks++; if (credits !== 4'd5) begin errors++; $display("FAIL sp_credits got %0d want 5", credits); end
      req = 4'b0000; last = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [0:4];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      RST = 1'b1; cyc(); RST = 1'b0;
      req = 4'b1111; last = 4'b1111; tx_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, grant, exp_g[k]); end
         cyc();
         checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d got %b want 1", k, tx_valid); end
         cyc();
         checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_release%0d got %b want 0000", k, grant); end
      end
      checks++; if (credits !== 4'd3) begin errors++; $display("FAIL rr_credits got %0d want 3", credits); end
      req = 4'b0000; last = 4'b0000;
   endtask

   task automatic test_reset_mid_packet();
      req = 4'b0010; tx_ready = 1'b0;
      cyc();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mr_grant got %b want 0010", grant); end
      cyc();
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mr_valid got %b want 1", tx_valid); end
      checks++; if (credits !== 4'd3) begin errors++; $display("FAIL mr_pre_credits got %0d want 3", credits); end
      RST = 1'b1; tx_ready = 1'b1;
      #1;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_in_rst got %b want 0", tx_valid); end
      cyc();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mr_grant_rst got %b want 0000", grant); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_rst got %b want 0", tx_valid); end
      checks++; if (credits !== 4'd8) begin errors++; $display("FAIL mr_credits got %0d want 8", credits); end
      RST = 1'b0; req = 4'b0000;
   endtask

   task automatic test_stall();
      req = 4'b0001; tx_ready = 1'b1; last = 4'b0000;
      cyc(); cyc();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) last = 4'b0001;
         cyc();
      end
      req = 4'b0000; last = 4'b0000;
      checks++; if (credits !== 4'd2) begin errors++; $display("FAIL st_pre_credits got %0d want 2", credits); end
      req = 4'b0010;
      cyc();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL st_grant got %b want 0010", grant); end
      cyc(); cyc();
      checks++; if (credits !== 4'd1) begin errors++; $display("FAIL st_beat1 got %0d want 1", credits); end
      cyc();
      checks++; if (credits !== 4'd0) begin errors++; $display("FAIL st_beat2 got %0d want 0", credits); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL st_valid got %b want 0", tx_valid); end
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL st_hold got %b want 0010", grant); end
      cyc();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL st_wait_valid got %b want 0", tx_valid); end
      credit_ret = 1'b1;
      cyc();
      credit_ret = 1'b0;
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL st_resume got %b want 1", tx_valid); end
      checks++; if (credits !== 4'd1) begin errors++; $display("FAIL st_ret_credits got %0d want 1", credits); end
      cyc();
      checks++; if (credits !== 4'd0) begin errors++; $display("FAIL st_beat3 got %0d want 0", credits); end
      credit_ret = 1'b1;
      cyc();
      credit_ret = 1'b0; last = 4'b0010;
      cyc();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL st_end_grant got %b want 0000", grant); end
      checks++; if (credits !== 4'd0) begin errors++; $display("FAIL st_end_credits got %0d want 0", credits); end
      req = 4'b0001; last = 4'b0000;
      cyc(); cyc();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL st_no_credit_grant got %b want 0000", grant); end
      req = 4'b0000;
   endtask

   task automatic test_saturation();
      credit_ret = 1'b1;
      for (int i = 0; i < 15; i++) cyc();
      checks++; if (credits !== 4'd15) begin errors++; $display("FAIL sat_fill got %0d want 15", credits); end
      checks++; if (credit_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_early got %b want 0", credit_ovf); end
      cyc();
      checks++; if (credits !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", credits); end
      checks++; if (credit_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", credit_ovf); end
      credit_ret = 1'b0;
      cyc();
      checks++; if (credit_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_pulse got %b want 0", credit_ovf); end
      req = 4'b0001; tx_ready = 1'b1; last = 4'b0000;
      cyc();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sat_grant got %b want 0001", grant); end
      cyc();
      credit_ret = 1'b1;
      cyc();
      credit_ret = 1'b0;
      checks++; if (credits !== 4'd15) begin errors++; $display("FAIL sat_send_ret got %0d want 15", credits); end
      checks++; if (credit_ovf !== 1'b0) begin errors++; $display("FAIL sat_send_ovf got %b want 0", credit_ovf); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sat_grant_kept got %b want 0001", grant); end
      last = 4'b0001;
      cyc();
      checks++; if (credits !== 4'd14) begin errors++; $display("FAIL sat_last got %0d want 14", credits); end
      req = 4'b0000; last = 4'b0000;
   endtask

   task automatic test_req_drop();
      req = 4'b0100; tx_ready = 1'b0;
      cyc();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL drop_grant got %b want 0100", grant); end
      cyc();
      req = 4'b0000;
      cyc();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_release got %b want 0000", grant); end
      req = 4'b1111;
      cyc();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_ptr got %b want 1000", grant); end
      req = 4'b0000;
      cyc();
   endtask

`ifdef CREDIT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      RST = 1'b1; cyc(); RST = 1'b0;
      req = 4'b0001; tx_ready = 1'b1; last = 4'b0000;
      cyc(); cyc();
      for (int i = 0; i < 8; i++) cyc();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL to_stall got %b want 0", tx_valid); end
      cyc(); cyc(); cyc();
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", stall_err); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_hold got %b want 0001", grant); end
      cyc();
      checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", stall_err); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_grant got %b want 0000", grant); end
      checks++; if (credits !== 4'd0) begin errors++; $display("FAIL to_credits got %0d want 0", credits); end
      cyc();
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b want 0", stall_err); end
      req = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_reset_mid_packet();
      test_stall();
      test_saturation();
      test_req_drop();
`ifdef CREDIT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
